// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Purpose  : Shared constants and types for the Morse input sequencer.
//            DOT/DASH symbol encoding, maximum symbols per character and the
//            sequencer FSM state type.
// Revision : 1.0  initial release
// ============================================================================
package morse_pkg;

  localparam logic DOT         = 1'b0;
  localparam logic DASH        = 1'b1;
  localparam int   MAX_SYMBOLS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/morse_debounce.sv
`default_nettype none
// ============================================================================
// Module   : morse_debounce
// Purpose  : One raw asynchronous key -> 2-FF synchronizer -> debounce filter
//            -> registered one-cycle rising-edge pulse.
// Ports    : clk     system clock
//            rst_n   asynchronous active-low reset
//            raw_in  raw asynchronous key level
//            rise    one-cycle pulse, DEBOUNCE_CYCLES+3 cycles after a clean
//                    0->1 step on raw_in
// Revision : 1.0  initial release
// ============================================================================
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = raw_in;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    // Registered edge so the pulse is glitch-free and lands a fixed
    // latency after the debounced level flips.
    rise_d      = level_q & ~level_dly_q;
    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/morse_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morse_input_sequencer
// Purpose  : Collects debounced dot/dash key presses into a Morse character
//            of up to five symbols and commits it on a done key or after an
//            idle gap, holding it until the consumer accepts it.
// Ports    : clk, rst_n      clock, asynchronous active-low reset
//            button_in[1:0]  raw keys, bit0 dot, bit1 dash
//            switch_in[3:0]  raw switches, bit0 is done
//            commit_ready    consumer accepts the held character
//            status_clr      clears the sticky status flags
//            commit_valid    committed character is being held
//            commit_sym[4:0] symbols, first in bit0, dot=0 dash=1
//            commit_len[2:0] symbol count 1..5
//            busy            high while collecting or holding
//            status[1:0]     sticky flags, bit0 err, bit1 drop
// Revision : 1.0  initial release
// ============================================================================
module morse_input_sequencer
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int GAP_CYCLES      = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] button_in,
  input  logic [3:0] switch_in,
  input  logic       commit_ready,
  input  logic       status_clr,
  output logic       commit_valid,
  output logic [4:0] commit_sym,
  output logic [2:0] commit_len,
  output logic       busy,
  output logic [1:0] status
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = {GAP_W{1'b1}};

  logic dot_p, dash_p, done_p;

  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dot (
    .clk(clk), .rst_n(rst_n), .raw_in(button_in[0]), .rise(dot_p)
  );
  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dash (
    .clk(clk), .rst_n(rst_n), .raw_in(button_in[1]), .rise(dash_p)
  );
  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (
    .clk(clk), .rst_n(rst_n), .raw_in(switch_in[0]), .rise(done_p)
  );

  // Only the done switch is wired into the sequencer.
  logic unused_switch;
  assign unused_switch = ^switch_in[3:1];

  state_t           state_q, state_d;
  logic [4:0]       buf_q, buf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_sym_q, commit_sym_d;
  logic [2:0]       commit_len_q, commit_len_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;

  logic       both_keys, one_key, sym_bit;
  logic [4:0] next_buf;
  logic [2:0] next_cnt;

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    commit_valid_d = commit_valid_q;
    commit_sym_d   = commit_sym_q;
    commit_len_d   = commit_len_q;
    // Set events below override the clear in the same cycle.
    err_d          = err_q & ~status_clr;
    drop_d         = drop_q & ~status_clr;
    both_keys      = dot_p & dash_p;
    one_key        = dot_p ^ dash_p;
    sym_bit        = dash_p ? DASH : DOT;
    next_buf       = buf_q;
    next_cnt       = cnt_q;

    // Simultaneous keys are ambiguous: both are discarded in every state.
    if (both_keys) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (one_key) begin
          buf_d   = {4'b0000, sym_bit};
          cnt_d   = 3'd1;
          gap_d   = '0;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (gap_q != GAP_SAT) begin
          gap_d = gap_q + GAP_W'(1);
        end
        if (one_key) begin
          if (cnt_q < 3'(MAX_SYMBOLS)) begin
            next_buf = buf_q | (5'(sym_bit) << cnt_q);
            next_cnt = cnt_q + 3'd1;
            gap_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        buf_d = next_buf;
        cnt_d = next_cnt;
        // A symbol arriving with done is folded into the commit.
        if (done_p || (gap_q == GAP_LAST)) begin
          commit_sym_d   = next_buf;
          commit_len_d   = next_cnt;
          commit_valid_d = 1'b1;
          gap_d          = '0;
          state_d        = HOLD;
        end
      end

      HOLD: begin
        if (dot_p | dash_p) begin
          drop_d = 1'b1;
        end
        if (commit_ready) begin
          state_d        = IDLE;
          buf_d          = '0;
          cnt_d          = '0;
          commit_valid_d = 1'b0;
          commit_sym_d   = '0;
          commit_len_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      commit_valid_q <= 1'b0;
      commit_sym_q   <= '0;
      commit_len_q   <= '0;
      err_q          <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      commit_valid_q <= commit_valid_d;
      commit_sym_q   <= commit_sym_d;
      commit_len_q   <= commit_len_d;
      err_q          <= err_d;
      drop_q         <= drop_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_sym   = commit_sym_q;
  assign commit_len   = commit_len_q;
  assign busy         = (state_q != IDLE);
  assign status       = {drop_q, err_q};

endmodule
`default_nettype wire
